// File: rtl/pu_pio_ctrl_pkg.sv
// Shared definitions for the PU PIO master: bus width, default timing parameters,
// controller state encoding and a counter-width helper.
package pu_pio_ctrl_pkg;

   localparam int PIO_NBITS      = 32;
   localparam int PU_PIO_TIMEOUT = 255;
   localparam int PU_PIO_DIV     = 4;

   typedef enum logic [2:0] {
      PIO_ST_IDLE     = 3'd0,
      PIO_ST_ISSUE    = 3'd1,
      PIO_ST_WAIT_ACK = 3'd2,
      PIO_ST_RELEASE  = 3'd3,
      PIO_ST_DONE     = 3'd4
   } pio_state_e;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pu_pio_ctrl_clk_div.sv
// Free-running divider producing a one-cycle enable every DIV_RATIO clocks;
// shared by the PU PIO master and slaves.
module pu_clk_div_gen
   import pu_pio_ctrl_pkg::*;
#(
   parameter int DIV_RATIO = PU_PIO_DIV
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic pulse_o
);

   localparam int            CW   = cnt_width(DIV_RATIO - 1);
   localparam logic [CW-1:0] LAST = CW'(DIV_RATIO - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Gated by reset so the enable is low while the block is held in reset.
   assign pulse_o = ~rst_i & (cnt_q == LAST);

endmodule

// File: rtl/pu_pio_ctrl.sv
// Upstream PIO master: takes one host register request at a time, drives the
// decoder strobes, waits for its ack (with timeout) and returns a completion.
module pu_pio_ctrl
   import pu_pio_ctrl_pkg::*;
#(
   parameter int DIV_RATIO      = PU_PIO_DIV,
   parameter int TIMEOUT_CYCLES = PU_PIO_TIMEOUT,
   parameter int NBITS          = PIO_NBITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             host_req,
   output logic             host_rdy,
   input  logic             host_wr,
   input  logic [NBITS-1:0] host_addr,
   input  logic [NBITS-1:0] host_wdata,
   output logic             host_ack,
   output logic [NBITS-1:0] host_rdata,
   output logic             host_err,
   output logic             clk_div,
   output logic             reg_bs,
   output logic             reg_rd,
   output logic             reg_wr,
   output logic [NBITS-1:0] reg_addr,
   output logic [NBITS-1:0] reg_din,
   input  logic             pio_ack,
   input  logic             pio_rvalid,
   input  logic [NBITS-1:0] pio_rdata
);

   localparam int            TW      = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

   pio_state_e       state_q, state_d;
   logic [TW-1:0]    tcnt_q, tcnt_d, tcnt_inc;
   logic             timed_out;
   logic             wr_q, wr_d;
   logic             err_q, err_d;
   logic [NBITS-1:0] addr_q, addr_d;
   logic [NBITS-1:0] din_q, din_d;
   logic [NBITS-1:0] rdata_q, rdata_d;

   pu_clk_div_gen #(
      .DIV_RATIO(DIV_RATIO)
   ) u_clk_div (
      .clk_i  (clk),
      .rst_i  (rst),
      .pulse_o(clk_div)
   );

   assign tcnt_inc  = (tcnt_q == TO_MAX) ? tcnt_q : tcnt_q + TW'(1);
   assign timed_out = (tcnt_q >= TO_LAST);

   // The timeout counter only runs in the two states that wait on the decoder;
   // everywhere else it is held at zero so each wait starts fresh.
   always_comb begin
      state_d = state_q;
      tcnt_d  = '0;
      wr_d    = wr_q;
      err_d   = err_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rdata_d = rdata_q;
      case (state_q)
         PIO_ST_IDLE: begin
            if (host_req && host_rdy) begin
               wr_d    = host_wr;
               addr_d  = host_addr;
               din_d   = host_wdata;
               state_d = PIO_ST_ISSUE;
            end
         end
         PIO_ST_ISSUE: begin
            state_d = PIO_ST_WAIT_ACK;
         end
         PIO_ST_WAIT_ACK: begin
            tcnt_d = tcnt_inc;
            if (pio_ack) begin
               err_d = ~pio_rvalid;
               if (!wr_q) begin
                  rdata_d = pio_rvalid ? pio_rdata : '0;
               end
               state_d = PIO_ST_DONE;
            end else if (timed_out) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = PIO_ST_DONE;
            end
         end
         PIO_ST_DONE: begin
            state_d = PIO_ST_RELEASE;
         end
         PIO_ST_RELEASE: begin
            tcnt_d = tcnt_inc;
            if (!pio_ack || timed_out) begin
               addr_d  = '0;
               din_d   = '0;
               state_d = PIO_ST_IDLE;
            end
         end
         default: begin
            state_d = PIO_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PIO_ST_IDLE;
         tcnt_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decode from the asynchronously reset state, so reset drops them at once.
   assign host_rdy   = ~rst & (state_q == PIO_ST_IDLE) & ~pio_ack;
   assign reg_bs     = (state_q == PIO_ST_ISSUE) | (state_q == PIO_ST_WAIT_ACK);
   assign reg_rd     = (state_q == PIO_ST_ISSUE) & ~wr_q;
   assign reg_wr     = (state_q == PIO_ST_ISSUE) & wr_q;
   assign host_ack   = (state_q == PIO_ST_DONE);
   assign host_err   = (state_q == PIO_ST_DONE) & err_q;
   assign host_rdata = rdata_q;
   assign reg_addr   = addr_q;
   assign reg_din    = din_q;

endmodule

// File: tb/tb_pu_pio_ctrl.sv
// Randomised bench for pu_pio_ctrl: a decoder responder, a transaction-level
// reference model checked every cycle, and directed literal pins.
module tb_pu_pio_ctrl;

   localparam int NB       = 32;
   localparam int DIV      = 4;
   localparam int TO       = 255;
   localparam int MAPPED   = 0;
   localparam int UNMAPPED = 1;
   localparam int NOACK    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          host_req = 1'b0;
   logic          host_wr = 1'b0;
   logic [NB-1:0] host_addr = '0;
   logic [NB-1:0] host_wdata = '0;
   logic          pio_ack = 1'b0;
   logic          pio_rvalid = 1'b0;
   logic [NB-1:0] pio_rdata = '0;
   logic          host_rdy, host_ack, host_err, clk_div, reg_bs, reg_rd, reg_wr;
   logic [NB-1:0] host_rdata, reg_addr, reg_din;

   logic          d1_host_rdy, d1_host_ack, d1_host_err, d1_clk_div;
   logic          d1_reg_bs, d1_reg_rd, d1_reg_wr;
   logic [NB-1:0] d1_host_rdata, d1_reg_addr, d1_reg_din;

   int assertCount = 0;
   int failCount   = 0;

   int            decMode = MAPPED;
   int            ackDelay = 1;
   logic [NB-1:0] decData = '0;
   int            pulses = 0;
   bit            pending = 1'b0;

   bit            busy = 1'b0;
   bit            completed = 1'b0;
   bit            mWr = 1'b0;
   bit            expErr = 1'b0;
   bit            expRdy;
   bit            rdataKnown = 1'b1;
   int            age = 0;
   int            compAge = 0;
   int            divCycle = 0;
   logic [NB-1:0] mAddr = '0;
   logic [NB-1:0] mDin = '0;
   logic [NB-1:0] heldRdata = '0;

   pu_pio_ctrl #(.DIV_RATIO(DIV), .TIMEOUT_CYCLES(TO), .NBITS(NB)) dut (
      .clk(clk), .rst(rst), .host_req(host_req), .host_rdy(host_rdy), .host_wr(host_wr),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
      .host_rdata(host_rdata), .host_err(host_err), .clk_div(clk_div), .reg_bs(reg_bs),
      .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_din(reg_din),
      .pio_ack(pio_ack), .pio_rvalid(pio_rvalid), .pio_rdata(pio_rdata)
   );

   pu_pio_ctrl #(.DIV_RATIO(1), .TIMEOUT_CYCLES(TO), .NBITS(NB)) dut1 (
      .clk(clk), .rst(rst), .host_req(1'b0), .host_rdy(d1_host_rdy), .host_wr(1'b0),
      .host_addr('0), .host_wdata('0), .host_ack(d1_host_ack),
      .host_rdata(d1_host_rdata), .host_err(d1_host_err), .clk_div(d1_clk_div),
      .reg_bs(d1_reg_bs), .reg_rd(d1_reg_rd), .reg_wr(d1_reg_wr), .reg_addr(d1_reg_addr),
      .reg_din(d1_reg_din), .pio_ack(1'b0), .pio_rvalid(1'b0), .pio_rdata('0)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [NB-1:0] actual,
                              input logic [NB-1:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkFlag(input string name, input logic actual, input logic expected);
      checkOutput(name, {{(NB-1){1'b0}}, actual}, {{(NB-1){1'b0}}, expected});
   endtask

   // Decoder stand-in: acks a strobe after ackDelay clk_div pulses and drops the
   // ack on a later pulse once bus select has gone away.
   always @(negedge clk) begin
      if (rst) begin
         pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0; pending = 1'b0; pulses = 0;
      end else begin
         if (clk_div) begin
            if (pending) begin
               pulses++;
               if (pulses >= ackDelay) begin
                  pending    = 1'b0;
                  pio_ack    = 1'b1;
                  pio_rvalid = (decMode == MAPPED);
                  pio_rdata  = decData;
               end
            end else if (pio_ack && !reg_bs) begin
               pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
            end
         end
         if ((reg_rd || reg_wr) && decMode != NOACK) begin
            pending = 1'b1;
            pulses  = 0;
         end
      end
   end

   // Reference model: each accepted request is tracked by its age in cycles since
   // acceptance; completion age is fixed by the first ack or by the timeout.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         checkFlag("rst_host_rdy", host_rdy, 1'b0);
         checkFlag("rst_host_ack", host_ack, 1'b0);
         checkFlag("rst_reg_bs", reg_bs, 1'b0);
         checkFlag("rst_strobes", reg_rd | reg_wr, 1'b0);
         checkFlag("rst_clk_div", clk_div, 1'b0);
         checkFlag("rst_d1_clk_div", d1_clk_div, 1'b0);
         checkOutput("rst_reg_addr", reg_addr, '0);
         checkOutput("rst_host_rdata", host_rdata, '0);
         busy = 1'b0; completed = 1'b0; heldRdata = '0; rdataKnown = 1'b1; divCycle = 0;
      end else begin
         expRdy = !busy && !pio_ack;
         checkFlag("clk_div", clk_div, (divCycle % DIV) == DIV - 1);
         checkFlag("d1_clk_div", d1_clk_div, 1'b1);
         checkFlag("d1_host_rdy", d1_host_rdy, 1'b1);
         checkFlag("d1_quiet", |{d1_host_ack, d1_host_err, d1_reg_bs, d1_reg_rd, d1_reg_wr,
                                 d1_host_rdata, d1_reg_addr, d1_reg_din}, 1'b0);
         checkFlag("host_rdy", host_rdy, expRdy);
         checkFlag("reg_rd", reg_rd, busy && age == 1 && !mWr);
         checkFlag("reg_wr", reg_wr, busy && age == 1 && mWr);
         checkFlag("reg_bs", reg_bs, busy && !completed);
         checkFlag("host_ack", host_ack, busy && completed && age == compAge);
         checkFlag("host_err", host_err, busy && completed && age == compAge && expErr);
         checkOutput("reg_addr", reg_addr, busy ? mAddr : '0);
         checkOutput("reg_din", reg_din, busy ? mDin : '0);
         if (rdataKnown) checkOutput("host_rdata", host_rdata, heldRdata);

         divCycle++;
         if (busy) begin
            if (!completed) begin
               if (age >= 2) begin
                  if (pio_ack) begin
                     completed = 1'b1; compAge = age + 1; expErr = !pio_rvalid;
                     if (!mWr) begin
                        heldRdata = pio_rvalid ? pio_rdata : '0; rdataKnown = 1'b1;
                     end else begin
                        rdataKnown = 1'b0;
                     end
                  end else if (age - 2 == TO - 1) begin
                     completed = 1'b1; compAge = age + 1; expErr = 1'b1;
                     heldRdata = '0; rdataKnown = 1'b1;
                  end
               end
            end else if (age > compAge) begin
               if (!pio_ack || (age - compAge - 1) == TO - 1) busy = 1'b0;
            end
            age++;
         end else if (host_req && expRdy) begin
            busy = 1'b1; completed = 1'b0; age = 1;
            mWr = host_wr; mAddr = host_addr; mDin = host_wdata;
         end
      end
   end

   task automatic applyStimulus(input bit wr, input logic [NB-1:0] addr, input logic [NB-1:0] wdata,
                                input int mode, input int dly, input logic [NB-1:0] data,
                                output logic [NB-1:0] rd, output logic er, output int lat,
                                output logic [NB-1:0] ackAddr, output logic [NB-1:0] ackDin);
      int n;
      bit got;
      decMode = mode; ackDelay = dly; decData = data;
      rd = '0; er = 1'b0; ackAddr = '0; ackDin = '0;
      @(posedge clk); #2;
      host_req = 1'b1; host_wr = wr; host_addr = addr; host_wdata = wdata;
      n = 0; got = 1'b0;
      while (!got && n < 1000) begin
         @(negedge clk); #2;
         if (host_rdy) got = 1'b1; else n++;
      end
      checkFlag("accept_bound", got, 1'b1);
      @(posedge clk); #2;
      host_req = 1'b0; host_wr = 1'($urandom); host_addr = $urandom; host_wdata = $urandom;
      n = 0; got = 1'b0;
      while (!got && n < 1000) begin
         @(negedge clk); #2;
         n++;
         if (host_ack) begin
            got = 1'b1; rd = host_rdata; er = host_err; ackAddr = reg_addr; ackDin = reg_din;
         end
      end
      checkFlag("ack_bound", got, 1'b1);
      lat = n;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [NB-1:0] rd, ad, dn;
      logic          er;
      int            lat, n, mode;
      bit            got;

      repeat (3) @(posedge clk);
      #1;
      checkFlag("reset_host_rdy", host_rdy, 1'b0);
      checkFlag("reset_clk_div", clk_div, 1'b0);
      #1 rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk); #2; n++;
      end while (!clk_div && n < 10);
      checkOutput("first_clk_div_cycle", n, 4);

      applyStimulus(1'b0, 32'h0000_0040, 32'hDEAD_BEEF, MAPPED, 2, 32'hA5A5_0001, rd, er, lat, ad, dn);
      checkOutput("read_rdata", rd, 32'hA5A5_0001);
      checkFlag("read_err", er, 1'b0);
      checkFlag("read_min_latency", lat >= 3, 1'b1);

      applyStimulus(1'b1, 32'h0000_1004, 32'h1234_5678, MAPPED, 1, 32'h5555_AAAA, rd, er, lat, ad, dn);
      checkOutput("write_reg_addr", ad, 32'h0000_1004);
      checkOutput("write_reg_din", dn, 32'h1234_5678);
      checkFlag("write_err", er, 1'b0);
      checkFlag("write_rdy_at_ack", host_rdy, 1'b0);

      applyStimulus(1'b0, 32'h0000_0F00, 32'h0, UNMAPPED, 1, 32'hFFFF_0000, rd, er, lat, ad, dn);
      checkOutput("unmapped_rdata", rd, 32'h0);
      checkFlag("unmapped_err", er, 1'b1);

      applyStimulus(1'b0, 32'h0000_0100, 32'h0, NOACK, 1, 32'h0, rd, er, lat, ad, dn);
      checkOutput("timeout_latency", lat, 257);
      checkFlag("timeout_err", er, 1'b1);
      checkOutput("timeout_rdata", rd, 32'h0);

      decMode = NOACK;
      @(posedge clk); #2;
      host_req = 1'b1; host_wr = 1'b0; host_addr = 32'h0000_0080;
      n = 0; got = 1'b0;
      while (!got && n < 1000) begin
         @(negedge clk); #2;
         if (host_rdy) got = 1'b1; else n++;
      end
      checkFlag("rst_test_accept", got, 1'b1);
      @(posedge clk); #2 host_req = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      checkFlag("pre_rst_reg_bs", reg_bs, 1'b1);
      rst = 1'b1;
      #1;
      checkFlag("async_rst_reg_bs", reg_bs, 1'b0);
      checkFlag("async_rst_strobes", reg_rd | reg_wr, 1'b0);
      checkFlag("async_rst_host_ack", host_ack, 1'b0);
      checkOutput("async_rst_reg_addr", reg_addr, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      applyStimulus(1'b0, 32'h0000_0044, 32'h0, MAPPED, 1, 32'h0BAD_F00D, rd, er, lat, ad, dn);
      checkOutput("post_rst_rdata", rd, 32'h0BAD_F00D);
      checkFlag("post_rst_err", er, 1'b0);

      for (int i = 0; i < 30; i++) begin
         n = $urandom_range(0, 9);
         mode = (n < 7) ? MAPPED : (n < 9) ? UNMAPPED : NOACK;
         applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, mode,
                       $urandom_range(1, 3), $urandom, rd, er, lat, ad, dn);
         checkFlag("rand_err", er, mode != MAPPED);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (20) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
